// File: rtl/count_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | count_pkg                                                             |
// | Shared types and default widths for the counter and its checker.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package count_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_STAT_W   = 8;
  localparam int DEF_SYNC_LEN = 2;

endpackage : count_pkg
`default_nettype wire

// File: rtl/count_checker_sat_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sat_counter                                                           |
// | Up-counter that sticks at all-ones instead of wrapping.               |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/count_checker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | count_checker                                                         |
// | Monitors a free-running counter bus and flags any non +1 step.        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module count_checker
  import count_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int SYNC_LEN = DEF_SYNC_LEN,
  parameter int STAT_W   = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [WIDTH-1:0]  count,
  output logic              locked,
  output logic              error,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count,
  output logic [WIDTH-1:0]  last_good
);

  localparam logic [1:0] c_st_idle   = IDLE;
  localparam logic [1:0] c_st_sync   = SYNC;
  localparam logic [1:0] c_st_locked = LOCKED;
  localparam logic [3:0] c_sync_len  = 4'(SYNC_LEN);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_prev;
  logic [3:0]       r_match;
  logic             r_locked;
  logic             r_error;
  logic [WIDTH-1:0] r_last_good;

  logic [WIDTH-1:0] w_nxt;
  logic             w_hit;
  logic             w_err_inc;
  logic             w_wrap_inc;

  assign w_nxt = r_prev + 1'b1;
  assign w_hit = (count == w_nxt);

  // Statistic strobes line up with the edge that updates error/last_good.
  assign w_err_inc  = en && (r_state == c_st_locked) && !w_hit;
  assign w_wrap_inc = en && (r_state == c_st_locked) && w_hit &&
                      (r_prev == {WIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= c_st_idle;
      r_prev      <= '0;
      r_match     <= '0;
      r_locked    <= 1'b0;
      r_error     <= 1'b0;
      r_last_good <= '0;
    end else begin
      r_error <= 1'b0;
      if (en) begin
        case (r_state)
          c_st_idle: begin
            r_prev  <= count;
            r_match <= '0;
            r_state <= c_st_sync;
          end
          c_st_sync: begin
            r_prev <= count;
            if (w_hit) begin
              r_last_good <= count;
              r_match     <= r_match + 4'd1;
              if ((r_match + 4'd1) == c_sync_len) begin
                r_state  <= c_st_locked;
                r_locked <= 1'b1;
              end
            end else begin
              r_match <= '0;
            end
          end
          c_st_locked: begin
            r_prev <= count;
            if (w_hit) begin
              r_last_good <= count;
            end else begin
              r_error  <= 1'b1;
              r_locked <= 1'b0;
              r_match  <= '0;
              r_state  <= c_st_sync;
            end
          end
          default: begin
            r_state  <= c_st_idle;
            r_locked <= 1'b0;
            r_match  <= '0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(STAT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_err_inc),
    .q     (err_count)
  );

  sat_counter #(.W(STAT_W)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_wrap_inc),
    .q     (wrap_count)
  );

  assign locked    = r_locked;
  assign error     = r_error;
  assign last_good = r_last_good;

endmodule : count_checker
`default_nettype wire

// File: tb/tb_count_checker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_count_checker                                                      |
// | Directed self-checking bench for count_checker.                       |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_count_checker;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] count;
  logic       locked;
  logic       error;
  logic [7:0] err_count;
  logic [7:0] wrap_count;
  logic [7:0] last_good;

  int n_total;
  int n_pass;

  count_checker #(.WIDTH(8), .SYNC_LEN(2), .STAT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .count      (count),
    .locked     (locked),
    .error      (error),
    .err_count  (err_count),
    .wrap_count (wrap_count),
    .last_good  (last_good)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Apply one sample, then settle just past the sampling edge.
  task automatic step(input logic e, input logic [7:0] c);
    en    = e;
    count = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic lk, input logic er,
                           input logic [7:0] ec, input logic [7:0] wc,
                           input logic [7:0] lg);
    check({tag, ".locked"},     32'(locked),     32'(lk));
    check({tag, ".error"},      32'(error),      32'(er));
    check({tag, ".err_count"},  32'(err_count),  32'(ec));
    check({tag, ".wrap_count"}, 32'(wrap_count), 32'(wc));
    check({tag, ".last_good"},  32'(last_good),  32'(lg));
  endtask

  initial begin
    logic [7:0] p;
    logic [7:0] v;
    n_total = 0;
    n_pass  = 0;
    reset   = 1'b0;
    en      = 1'b0;
    count   = '0;

    step(1'b1, 8'd33);
    step(1'b0, 8'd0);
    check_all("reset", 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Acquire lock on 0,1,2
    step(1'b1, 8'd0);
    check_all("acq0", 0, 0, 0, 0, 0);
    step(1'b1, 8'd1);
    check_all("acq1", 0, 0, 0, 0, 1);
    step(1'b1, 8'd2);
    check_all("acq2", 1, 0, 0, 0, 2);
    for (int i = 3; i <= 6; i++) step(1'b1, 8'(i));
    check_all("run6", 1, 0, 0, 0, 6);

    // Skip 7
    step(1'b1, 8'd8);
    check_all("skip", 0, 1, 1, 0, 6);
    step(1'b1, 8'd9);
    check_all("resync9", 0, 0, 1, 0, 9);
    step(1'b1, 8'd10);
    check_all("relock10", 1, 0, 1, 0, 10);

    // Wrap-around
    for (int i = 11; i <= 255; i++) step(1'b1, 8'(i));
    check_all("run255", 1, 0, 1, 0, 255);
    step(1'b1, 8'd0);
    check_all("wrap0", 1, 0, 1, 1, 0);
    step(1'b1, 8'd1);
    check_all("wrap1", 1, 0, 1, 1, 1);

    // Stall and en gating
    step(1'b1, 8'd2);
    step(1'b1, 8'd2);
    check_all("stall", 0, 1, 2, 1, 2);
    step(1'b0, 8'd2);
    check_all("en0a", 0, 0, 2, 1, 2);
    step(1'b1, 8'd3);
    check_all("sync3", 0, 0, 2, 1, 3);
    step(1'b0, 8'd3);
    check_all("en0b", 0, 0, 2, 1, 3);
    step(1'b1, 8'd3);
    check_all("syncstall", 0, 0, 2, 1, 3);
    step(1'b1, 8'd4);
    step(1'b1, 8'd5);
    check_all("relock5", 1, 0, 2, 1, 5);
    step(1'b0, 8'd99);
    check_all("en0c", 1, 0, 2, 1, 5);
    step(1'b1, 8'd6);
    check_all("hold6", 1, 0, 2, 1, 6);

    // Third error, relock, then reset mid-operation
    step(1'b1, 8'd20);
    check_all("jump20", 0, 1, 3, 1, 6);
    step(1'b1, 8'd21);
    step(1'b1, 8'd22);
    check_all("relock22", 1, 0, 3, 1, 22);
    reset = 1'b0;
    step(1'b1, 8'd50);
    check_all("midreset", 0, 0, 0, 0, 0);
    reset = 1'b1;
    step(1'b1, 8'd77);
    check_all("post77", 0, 0, 0, 0, 0);
    step(1'b1, 8'd78);
    step(1'b1, 8'd79);
    check_all("post79", 1, 0, 0, 0, 79);

    // Saturation of err_count
    p = 8'd79;
    for (int i = 1; i <= 300; i++) begin
      v = p + 8'd5;
      step(1'b1, v);
      check("sat.error", 32'(error), 32'd1);
      if (i == 255) check("sat.err255", 32'(err_count), 32'd255);
      step(1'b1, v + 8'd1);
      step(1'b1, v + 8'd2);
      p = v + 8'd2;
    end
    check_all("satend", 1, 0, 255, 0, p);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_count_checker
`default_nettype wire
